multi_port_mem_ctrl: RTL and testbench

// - N-port byte-serial RAM controller: arbitrates reads/writes of 1..MAX_BYTES bytes between NUM_PORTS requesters
//   (port 0 = ICache line fetch, others = LSB/DCache) onto the single 8-bit RAM/UART bus.
// - Round-robin fairness, per-request byte count, UART-full write stall; successor of the fixed 2-client controller.

---
 rtl/mem_ctrl_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 28 ++
 rtl/multi_port_mem_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_multi_port_mem_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the multi-port byte-serial RAM controller.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  // Default request geometry: an ICache line of 8 bytes needs a 4-bit byte count.
  localparam int DEF_MAX_BYTES = 8;
  localparam int DEF_SIZE_W    = $clog2(DEF_MAX_BYTES + 1);

  // True when addr falls in the same 8-byte-aligned window as base (UART window).
  function automatic logic in_io_range(input logic [63:0] addr,
                                       input logic [63:0] base,
                                       input int          aw);
    logic [63:0] mask;
    mask      = (aw >= 64) ? '1 : ((64'd1 << aw) - 64'd1);
    mask[2:0] = 3'b000;
    return ((addr ^ base) & mask) == 64'd0;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches ports last_ptr+1 .. last_ptr (mod NUM_PORTS)
// and returns a one-hot grant for the first eligible one. Purely combinational.
module rr_arbiter #(
  parameter  int NUM_PORTS = 2,
  localparam int PTR_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] eligible,
  input  logic [PTR_W-1:0]     last_ptr,
  output logic [NUM_PORTS-1:0] grant
);

  // Rotating priority search starting just after the last granted port.
  always_comb begin
    int   idx;
    logic found;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      idx = (int'(last_ptr) + i) % NUM_PORTS;
      if (!found && eligible[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/multi_port_mem_ctrl.sv
// N-port byte-serial RAM/UART bus controller with round-robin arbitration.
// Optional feature macro: MEM_CTRL_FLUSH_EN adds a 'flush' input that aborts
// reads in flight and blocks LSB ports (1..N-1) from being accepted.
module multi_port_mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int                    NUM_PORTS  = 2,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    MAX_BYTES  = DEF_MAX_BYTES,
  parameter int                    SIZE_W     = DEF_SIZE_W,
  parameter logic [ADDR_WIDTH-1:0] IO_BASE    = ADDR_WIDTH'(32'h30000)
) (
  input  logic                            Sys_clk,
  input  logic                            Sys_rst_n,
  input  logic                            Sys_rdy,
  input  logic [7:0]                      ram_din,
  input  logic                            io_buffer_full,
  output logic [7:0]                      ram_dout,
  output logic [ADDR_WIDTH-1:0]           ram_addr,
  output logic                            ram_wr,
`ifdef MEM_CTRL_FLUSH_EN
  input  logic                            flush,
`endif
  input  logic [NUM_PORTS-1:0]            req_en,
  input  logic [NUM_PORTS-1:0]            req_wr,
  input  logic [NUM_PORTS*SIZE_W-1:0]     req_size,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_PORTS*8*MAX_BYTES-1:0] req_wdata,
  output logic [NUM_PORTS-1:0]            resp_done,
  output logic [8*MAX_BYTES-1:0]          resp_rdata
);

  localparam int PTR_W = $clog2(NUM_PORTS);

  state_e                  state_q, state_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic [SIZE_W-1:0]       cnt_q, cnt_d;
  logic [SIZE_W-1:0]       n_q, n_d;
  logic                    io_q, io_d;
  logic [ADDR_WIDTH-1:0]   ram_addr_q, ram_addr_d;
  logic [7:0]              ram_dout_q, ram_dout_d;
  logic                    ram_wr_q, ram_wr_d;
  logic [NUM_PORTS-1:0]    resp_done_q, resp_done_d;
  logic [8*MAX_BYTES-1:0]  resp_rdata_q, resp_rdata_d;

  logic [NUM_PORTS-1:0]    eligible, grant;
  logic                    any_grant;
  logic [PTR_W-1:0]        g_idx;
  logic [SIZE_W-1:0]       g_size;
  logic [ADDR_WIDTH-1:0]   g_addr;
  logic                    g_wr;
  logic [8*MAX_BYTES-1:0]  g_line, cur_line;
  logic                    flush_rd, flush_lsb;
  logic                    rd_last, wr_adv, wr_last;

  // Zero and oversize byte counts are normalised to the 1..MAX_BYTES range.
  function automatic logic [SIZE_W-1:0] clamp_size(input logic [SIZE_W-1:0] s);
    if (s == '0) return SIZE_W'(1);
    if (int'(s) > MAX_BYTES) return SIZE_W'(MAX_BYTES);
    return s;
  endfunction

  // Byte k of a write line; indices past the line yield zero.
  function automatic logic [7:0] pick_byte(input logic [8*MAX_BYTES-1:0] line,
                                           input logic [SIZE_W-1:0]      k);
    logic [7:0] r;
    r = 8'h00;
    for (int b = 0; b < MAX_BYTES; b++)
      if (int'(k) == b) r = line[8*b +: 8];
    return r;
  endfunction

`ifdef MEM_CTRL_FLUSH_EN
  assign flush_rd  = flush;
  assign flush_lsb = flush;
`else
  assign flush_rd  = 1'b0;
  assign flush_lsb = 1'b0;
`endif

  assign rd_last = (cnt_q == n_q);
  assign wr_adv  = ram_wr_q && !(io_q && io_buffer_full);
  assign wr_last = wr_adv && ((cnt_q + SIZE_W'(1)) == n_q);

  // Eligibility: pending, not just completed, not a UART write while UART is full.
  always_comb begin
    eligible = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      eligible[p] = req_en[p] && !resp_done_q[p] &&
                    !(req_wr[p] && io_buffer_full &&
                      in_io_range(64'(req_addr[p*ADDR_WIDTH +: ADDR_WIDTH]),
                                  64'(IO_BASE), ADDR_WIDTH));
      if (flush_lsb && p != 0) eligible[p] = 1'b0;
    end
  end

  rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (
    .eligible (eligible),
    .last_ptr (ptr_q),
    .grant    (grant)
  );

  assign any_grant = |grant;

  // Request mux: fields of the newly granted port and write line of the port in service.
  always_comb begin
    g_idx    = '0;
    g_size   = '0;
    g_addr   = '0;
    g_wr     = 1'b0;
    g_line   = '0;
    cur_line = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (grant[p]) begin
        g_idx  = PTR_W'(p);
        g_size = req_size[p*SIZE_W +: SIZE_W];
        g_addr = req_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
        g_wr   = req_wr[p];
        g_line = req_wdata[p*8*MAX_BYTES +: 8*MAX_BYTES];
      end
      if (PTR_W'(p) == ptr_q) cur_line = req_wdata[p*8*MAX_BYTES +: 8*MAX_BYTES];
    end
  end

  // State register; Sys_rdy low freezes every flop.
  always_ff @(posedge Sys_clk or negedge Sys_rst_n) begin
    if (!Sys_rst_n) begin
      state_q      <= ST_IDLE;
      ptr_q        <= PTR_W'(NUM_PORTS - 1);
      cnt_q        <= '0;
      n_q          <= '0;
      io_q         <= 1'b0;
      ram_addr_q   <= '0;
      ram_dout_q   <= '0;
      ram_wr_q     <= 1'b0;
      resp_done_q  <= '0;
      resp_rdata_q <= '0;
    end else if (Sys_rdy) begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      n_q          <= n_d;
      io_q         <= io_d;
      ram_addr_q   <= ram_addr_d;
      ram_dout_q   <= ram_dout_d;
      ram_wr_q     <= ram_wr_d;
      resp_done_q  <= resp_done_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  // Next-state: accept from IDLE, leave READ on last byte or flush, leave WRITE on last byte.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (any_grant) state_d = g_wr ? ST_WRITE : ST_READ;
      ST_READ:  if (flush_rd || rd_last) state_d = ST_IDLE;
      ST_WRITE: if (wr_last) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath/outputs: address stepping, byte capture, UART stall and completion pulse.
  always_comb begin
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    n_d          = n_q;
    io_d         = io_q;
    ram_addr_d   = ram_addr_q;
    ram_dout_d   = ram_dout_q;
    ram_wr_d     = ram_wr_q;
    resp_done_d  = resp_done_q;
    resp_rdata_d = resp_rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        resp_done_d = '0;
        if (any_grant) begin
          ptr_d      = g_idx;
          cnt_d      = '0;
          n_d        = clamp_size(g_size);
          io_d       = g_wr && in_io_range(64'(g_addr), 64'(IO_BASE), ADDR_WIDTH);
          ram_addr_d = g_addr;
          if (g_wr) begin
            ram_wr_d   = 1'b1;
            ram_dout_d = pick_byte(g_line, '0);
          end else begin
            ram_wr_d     = 1'b0;
            resp_rdata_d = '0;
          end
        end
      end
      ST_READ: begin
        if (flush_rd) begin
          ram_addr_d = '0;
        end else if (rd_last) begin
          ram_addr_d = '0;
          ram_wr_d   = 1'b0;
          for (int p = 0; p < NUM_PORTS; p++)
            if (PTR_W'(p) == ptr_q) resp_done_d[p] = 1'b1;
        end else begin
          for (int b = 0; b < MAX_BYTES; b++)
            if (int'(cnt_q) == b) resp_rdata_d[8*b +: 8] = ram_din;
          cnt_d      = cnt_q + SIZE_W'(1);
          ram_addr_d = ram_addr_q + ADDR_WIDTH'(1);
        end
      end
      ST_WRITE: begin
        if (!ram_wr_q) begin
          // Stalled on UART full: re-drive the pending byte once it drains.
          if (!io_buffer_full) ram_wr_d = 1'b1;
        end else if (io_q && io_buffer_full) begin
          ram_wr_d = 1'b0;
        end else if (wr_last) begin
          ram_wr_d   = 1'b0;
          ram_addr_d = '0;
          for (int p = 0; p < NUM_PORTS; p++)
            if (PTR_W'(p) == ptr_q) resp_done_d[p] = 1'b1;
        end else begin
          cnt_d      = cnt_q + SIZE_W'(1);
          ram_addr_d = ram_addr_q + ADDR_WIDTH'(1);
          ram_dout_d = pick_byte(cur_line, cnt_q + SIZE_W'(1));
        end
      end
      default: begin
        ram_wr_d = 1'b0;
      end
    endcase
  end

  assign ram_addr   = ram_addr_q;
  assign ram_dout   = ram_dout_q;
  assign ram_wr     = ram_wr_q;
  assign resp_done  = resp_done_q;
  assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_multi_port_mem_ctrl.sv
// Directed bench for multi_port_mem_ctrl (2 ports, 32-bit address, 8-byte lines).
// RAM model: byte at address a is {a[3:0]+1, a[3:0]+1}, returned combinationally.
module tb_multi_port_mem_ctrl;

  localparam int NP = 2;
  localparam int AW = 32;
  localparam int MB = 8;
  localparam int SW = 4;

  logic               Sys_clk = 1'b0;
  logic               Sys_rst_n;
  logic               Sys_rdy;
  logic [7:0]         ram_din;
  logic               io_buffer_full;
  logic [7:0]         ram_dout;
  logic [AW-1:0]      ram_addr;
  logic               ram_wr;
  logic [NP-1:0]      req_en;
  logic [NP-1:0]      req_wr;
  logic [NP*SW-1:0]   req_size;
  logic [NP*AW-1:0]   req_addr;
  logic [NP*8*MB-1:0] req_wdata;
  logic [NP-1:0]      resp_done;
  logic [8*MB-1:0]    resp_rdata;
`ifdef MEM_CTRL_FLUSH_EN
  logic               flush;
`endif

  int vectors     = 0;
  int miscompares = 0;

  logic [3:0] nib;
  assign nib     = ram_addr[3:0] + 4'd1;
  assign ram_din = {nib, nib};

  always #5 Sys_clk = ~Sys_clk;

  multi_port_mem_ctrl dut (
    .Sys_clk        (Sys_clk),
    .Sys_rst_n      (Sys_rst_n),
    .Sys_rdy        (Sys_rdy),
    .ram_din        (ram_din),
    .io_buffer_full (io_buffer_full),
    .ram_dout       (ram_dout),
    .ram_addr       (ram_addr),
    .ram_wr         (ram_wr),
`ifdef MEM_CTRL_FLUSH_EN
    .flush          (flush),
`endif
    .req_en         (req_en),
    .req_wr         (req_wr),
    .req_size       (req_size),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_done      (resp_done),
    .resp_rdata     (resp_rdata)
  );

  task automatic tick();
    @(posedge Sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  logic [31:0] exp_wrap [7];

  initial begin
    int n;
    exp_wrap = '{32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                 32'h0000_0000, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003};
    Sys_rst_n      = 1'b0;
    Sys_rdy        = 1'b1;
    io_buffer_full = 1'b0;
    req_en         = '0;
    req_wr         = '0;
    req_size       = '0;
    req_addr       = '0;
    req_wdata      = '0;
`ifdef MEM_CTRL_FLUSH_EN
    flush          = 1'b0;
`endif
    tick();
    tick();
    chk("rst_addr",  64'(ram_addr),   64'h0);
    chk("rst_wr",    64'(ram_wr),     64'h0);
    chk("rst_dout",  64'(ram_dout),   64'h0);
    chk("rst_done",  64'(resp_done),  64'h0);
    chk("rst_rdata", 64'(resp_rdata), 64'h0);
    Sys_rst_n = 1'b1;
    tick();

    // Port1 read 4 bytes @0x100
    req_wr = 2'b00; req_size[7:4] = 4'd4; req_addr[63:32] = 32'h100; req_en = 2'b10;
    tick();
    chk("t1_acc_addr", 64'(ram_addr), 64'h100);
    chk("t1_acc_wr",   64'(ram_wr),   64'h0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("t1_addr", 64'(ram_addr), 64'h100 + 64'(k));
    end
    tick();
    chk("t1_early", 64'(resp_done), 64'h0);
    tick();
    chk("t1_done",  64'(resp_done),  64'h2);
    chk("t1_rdata", 64'(resp_rdata), 64'h0000_0000_4433_2211);
    chk("t1_addr0", 64'(ram_addr),   64'h0);
    req_en = 2'b00;
    tick();
    chk("t1_clear", 64'(resp_done), 64'h0);

    // Port0 read 8 bytes @0xFFFF_FFFC with address wrap
    req_size[3:0] = 4'd8; req_addr[31:0] = 32'hFFFF_FFFC; req_en = 2'b01;
    tick();
    chk("t2_acc_addr", 64'(ram_addr), 64'hFFFF_FFFC);
    for (int k = 0; k < 7; k++) begin
      tick();
      chk("t2_wrap_addr", 64'(ram_addr), 64'(exp_wrap[k]));
    end
    tick();
    chk("t2_early", 64'(resp_done), 64'h0);
    tick();
    chk("t2_done",  64'(resp_done),  64'h1);
    chk("t2_rdata", 64'(resp_rdata), 64'h4433_2211_00FF_EEDD);
    req_en = 2'b00;
    tick();

    // Both ports requesting continuously: grants alternate
    req_size = {4'd1, 4'd1}; req_addr = {32'h21, 32'h13}; req_en = 2'b11;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      tick();
      while (resp_done == '0 && n < 8) begin
        tick();
        n++;
      end
      chk("t3_grant", 64'(resp_done),  (i % 2 == 0) ? 64'h2 : 64'h1);
      chk("t3_rdata", 64'(resp_rdata), (i % 2 == 0) ? 64'h22 : 64'h44);
    end
    req_en = 2'b00;
    tick();
    chk("t3_idle", 64'(resp_done), 64'h0);

    // Port1 UART write held off by full for 5 cycles
    io_buffer_full = 1'b1;
    req_wr = 2'b10; req_size[7:4] = 4'd1; req_addr[63:32] = 32'h30000;
    req_wdata[71:64] = 8'h41; req_en = 2'b10;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t4_held_wr", 64'(ram_wr), 64'h0);
    end
    io_buffer_full = 1'b0;
    tick();
    chk("t4_wr",   64'(ram_wr),   64'h1);
    chk("t4_addr", 64'(ram_addr), 64'h30000);
    chk("t4_dout", 64'(ram_dout), 64'h41);
    tick();
    chk("t4_wr_off", 64'(ram_wr),    64'h0);
    chk("t4_done",   64'(resp_done), 64'h2);
    req_en = 2'b00;
    tick();

    // Port0 UART write, stalled mid-transfer and resumed
    req_wr = 2'b01; req_size[3:0] = 4'd2; req_addr[31:0] = 32'h30004;
    req_wdata[15:0] = 16'hA55A; req_en = 2'b01;
    tick();
    chk("t4b_wr0",   64'(ram_wr),   64'h1);
    chk("t4b_dout0", 64'(ram_dout), 64'h5A);
    io_buffer_full = 1'b1;
    tick();
    chk("t4b_stall_wr",   64'(ram_wr),   64'h0);
    chk("t4b_stall_addr", 64'(ram_addr), 64'h30004);
    tick();
    chk("t4b_stall_wr2", 64'(ram_wr), 64'h0);
    io_buffer_full = 1'b0;
    tick();
    chk("t4b_resume_wr",   64'(ram_wr),   64'h1);
    chk("t4b_resume_dout", 64'(ram_dout), 64'h5A);
    chk("t4b_resume_addr", 64'(ram_addr), 64'h30004);
    tick();
    chk("t4b_b1_addr", 64'(ram_addr), 64'h30005);
    chk("t4b_b1_dout", 64'(ram_dout), 64'hA5);
    chk("t4b_b1_wr",   64'(ram_wr),   64'h1);
    tick();
    chk("t4b_done", 64'(resp_done), 64'h1);
    chk("t4b_wr",   64'(ram_wr),    64'h0);
    req_en = 2'b00;
    tick();

    // Port1 write 2 bytes 0xBEEF @0x200
    req_wr = 2'b10; req_size[7:4] = 4'd2; req_addr[63:32] = 32'h200;
    req_wdata[79:64] = 16'hBEEF; req_en = 2'b10;
    tick();
    chk("t5_addr0", 64'(ram_addr), 64'h200);
    chk("t5_dout0", 64'(ram_dout), 64'hEF);
    chk("t5_wr0",   64'(ram_wr),   64'h1);
    tick();
    chk("t5_addr1", 64'(ram_addr),  64'h201);
    chk("t5_dout1", 64'(ram_dout),  64'hBE);
    chk("t5_early", 64'(resp_done), 64'h0);
    tick();
    chk("t5_done", 64'(resp_done), 64'h2);
    chk("t5_wr",   64'(ram_wr),    64'h0);
    chk("t5_addr", 64'(ram_addr),  64'h0);
    req_en = 2'b00;
    tick();

    // Port0 read with size 0 behaves as size 1
    req_wr = 2'b00; req_size[3:0] = 4'd0; req_addr[31:0] = 32'h102; req_en = 2'b01;
    tick();
    chk("t6_addr", 64'(ram_addr), 64'h102);
    tick();
    chk("t6_early", 64'(resp_done), 64'h0);
    tick();
    chk("t6_done",  64'(resp_done),  64'h1);
    chk("t6_rdata", 64'(resp_rdata), 64'h33);
    req_en = 2'b00;
    tick();

    // Sys_rdy low freezes a port1 read in progress
    req_size[7:4] = 4'd2; req_addr[63:32] = 32'h108; req_en = 2'b10;
    tick();
    chk("t7_addr", 64'(ram_addr), 64'h108);
    Sys_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t7_frozen_addr", 64'(ram_addr), 64'h108);
    end
    Sys_rdy = 1'b1;
    tick();
    chk("t7_addr1", 64'(ram_addr), 64'h109);
    tick();
    chk("t7_addr2", 64'(ram_addr), 64'h10A);
    tick();
    chk("t7_done",  64'(resp_done),  64'h2);
    chk("t7_rdata", 64'(resp_rdata), 64'hAA99);
    req_en = 2'b00;
    tick();

    // Asynchronous reset in the middle of a port0 read
    req_size[3:0] = 4'd8; req_addr[31:0] = 32'h0; req_en = 2'b01;
    tick();
    tick();
    tick();
    #2 Sys_rst_n = 1'b0;
    #1;
    chk("t8_rst_addr",  64'(ram_addr),   64'h0);
    chk("t8_rst_rdata", 64'(resp_rdata), 64'h0);
    chk("t8_rst_done",  64'(resp_done),  64'h0);
    req_size = {4'd1, 4'd1}; req_addr = {32'h21, 32'h13}; req_en = 2'b11;
    #2 Sys_rst_n = 1'b1;
    tick();
    tick();
    tick();
    chk("t8_first_port0", 64'(resp_done),  64'h1);
    chk("t8_rdata",       64'(resp_rdata), 64'h44);
    req_en = 2'b00;
    tick();

`ifdef MEM_CTRL_FLUSH_EN
    // Flush aborts a port1 read; port0 is served next
    req_size = {4'd4, 4'd1}; req_addr = {32'h100, 32'h13}; req_en = 2'b11;
    tick();
    chk("tf_acc_addr", 64'(ram_addr), 64'h100);
    tick();
    tick();
    flush = 1'b1;
    tick();
    chk("tf_addr0", 64'(ram_addr),  64'h0);
    chk("tf_nodone", 64'(resp_done), 64'h0);
    flush  = 1'b0;
    req_en = 2'b01;
    tick();
    chk("tf_p0_addr", 64'(ram_addr), 64'h13);
    tick();
    chk("tf_nodone2", 64'(resp_done), 64'h0);
    tick();
    chk("tf_p0_done", 64'(resp_done), 64'h1);
    req_en = 2'b00;
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
